// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : RV32I fetch stage - PC generation, inst_mem handshake, 2-entry
//              instruction buffer with valid/ready decode interface.
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_INST = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_en,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                id_ready,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [31:0]         id_inst
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_req_pc;
  logic [PC_WIDTH-1:0] r_pc   [2];
  logic [31:0]         r_inst [2];
  logic [1:0]          r_count;

  logic w_grant;
  logic w_push;
  logic w_pop;
  logic w_unused;

  // Word alignment is forced, so the low redirect bits carry no information.
  assign w_unused  = &{1'b0, redirect_pc[1:0]};

  assign imem_req  = !rst && (r_state == ST_FETCH) && (r_count != 2'd2);
  assign imem_addr = r_fetch_pc;
  assign w_grant   = imem_req && imem_gnt;
  assign w_push    = (r_state == ST_WAIT) && imem_rvalid && !redirect_en;
  assign w_pop     = id_valid && id_ready && !redirect_en;

  assign id_valid  = (r_count != 2'd0);
  assign id_pc     = id_valid ? r_pc[0]   : '0;
  assign id_inst   = id_valid ? r_inst[0] : NOP_INST;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_count    <= 2'd0;
      r_pc[0]    <= '0;
      r_pc[1]    <= '0;
      r_inst[0]  <= NOP_INST;
      r_inst[1]  <= NOP_INST;
    end else if (redirect_en) begin
      r_fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      r_count    <= 2'd0;
      // A request still in flight after this edge must be drained first.
      case (r_state)
        ST_FETCH: r_state <= w_grant ? ST_DRAIN : ST_FETCH;
        default:  r_state <= imem_rvalid ? ST_FETCH : ST_DRAIN;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_grant) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT:  if (imem_rvalid) r_state <= ST_FETCH;
        ST_DRAIN: if (imem_rvalid) r_state <= ST_FETCH;
        default:  r_state <= ST_FETCH;
      endcase

      if (w_pop) begin
        r_pc[0]   <= r_pc[1];
        r_inst[0] <= r_inst[1];
      end
      // The new word lands in the first slot left free after any pop.
      if (w_push) begin
        if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
          r_pc[0]   <= r_req_pc;
          r_inst[0] <= imem_rdata;
        end else begin
          r_pc[1]   <= r_req_pc;
          r_inst[1] <= imem_rdata;
        end
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                   !(w_push && r_count == 2'd2));

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I pipeline.
- Generates the fetch PC, runs the request/grant/response handshake with inst_mem, and buffers fetched words in a 2-entry FIFO.
- Presents {pc, instruction} to the decode stage with a valid/ready handshake.
- Takes control-flow redirects from EX: loads the new PC, flushes the buffered instructions and discards any in-flight response.

Parameters:
- PC_WIDTH, 10, byte-address width of PC and imem_addr.
- RESET_PC, 0, fetch address after reset (bits [1:0] are 0).
- NOP_INST, 32'h00000013, instruction value driven on id_inst when id_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request to inst_mem.
- imem_addr  out  PC_WIDTH  fetch byte address; held stable while imem_req=1.
- imem_gnt  in  1  inst_mem accepts the request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  instruction word.
- redirect_en  in  1  EX requests a PC change.
- redirect_pc  in  PC_WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
- id_ready  in  1  decode stage accepts the head instruction.
- id_valid  out  1  head instruction is valid.
- id_pc  out  PC_WIDTH  PC of the head instruction.
- id_inst  out  32  head instruction; equals NOP_INST when id_valid=0.

Behaviour:
- Reset (rst=1 at an edge): fetch_pc=RESET_PC, FIFO count=0, state=FETCH. While rst=1, imem_req=0. One cycle after reset: id_valid=0, id_pc=0, id_inst=NOP_INST. Reset mid-transaction abandons the transaction; no later response is pushed until a new request is granted.
- Memory protocol:
  - At most one request outstanding.
  - The response arrives 1 or more cycles after the grant.
  - imem_rvalid is never asserted in the grant cycle.
- FSM states:
  - FETCH: imem_req = (count<2); imem_addr = fetch_pc. On imem_req & imem_gnt: req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^PC_WIDTH, so 0x3FC wraps to 0x000), go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {req_pc, imem_rdata} into the FIFO, go to FETCH.
  - DRAIN: imem_req=0. On imem_rvalid: discard the response, go to FETCH.
- Throughput: peak is one instruction per 2 cycles with zero-wait memory. There is no request in the cycle imem_rvalid is seen.
- FIFO:
  - 2 entries; the head drives id_pc/id_inst; id_valid = (count!=0).
  - A pop happens when id_valid & id_ready.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
  - Count is checked before the request is issued, so overflow cannot occur. Pushing when count=2 is a design error; flag it with an assertion in simulation.
- Redirect (redirect_en=1) has highest priority and overrides all other updates that cycle:
  - fetch_pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}; FIFO count <= 0, and any pop that cycle is ignored.
  - A response arriving in the redirect cycle is discarded.
  - Next state: DRAIN if a request is outstanding after this edge, i.e. in WAIT without imem_rvalid, or in FETCH with imem_gnt this cycle. Otherwise FETCH.
  - A redirect in DRAIN stays in DRAIN, or goes to FETCH if imem_rvalid arrives that same cycle.
  - imem_req may be asserted in the redirect cycle (stale address). If it is granted, that request is drained.
  - First request to the new PC: in the cycle after the redirect in the FETCH case, or in the cycle after the drained response arrives.
- Outputs id_valid/id_pc/id_inst are registered-state derived; there is no combinational path from imem_rdata to id_inst.

Test Plan:
- Zero-wait memory (gnt same cycle as req, rvalid one cycle later), id_ready=1 after reset: imem_addr sequence is 0x000, 0x004, 0x008. id_pc 0x000 appears 2 cycles after the first grant with id_inst = the returned word, then one instruction every 2 cycles.
- id_ready=0 throughout: FIFO holds PCs 0x000 and 0x004; imem_req stays 0 once count=2; id_pc stays 0x000. Raise id_ready for 1 cycle: id_pc becomes 0x004, and the next request is to 0x008.
- Redirect to 0x123 while in WAIT for 0x008 (response delayed 3 cycles): the late response is discarded, and id_valid stays 0 until a response arrives for new imem_addr 0x120. id_pc 0x120 is then presented, with no 0x008 instruction ever presented.
- Redirect in the same cycle as imem_rvalid with count=1: both the FIFO entry and the response are dropped; the next request is to redirect_pc in the following cycle.
- redirect_pc=0x3F8, zero-wait memory: requests go to 0x3F8, 0x3FC, then 0x000 (wrap).
- rst asserted for 1 cycle while in WAIT: imem_req=0 during reset, id_valid=0 after. A late rvalid is ignored (FETCH state, no outstanding request), and fetching restarts at RESET_PC.
